// File: rtl/sbqm_pkg.sv
// Shared types and helpers for the single-bank queue manager front end.
package sbqm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int TCOUNT_W = 2;
    localparam int MAX_NT   = 3;

    function automatic logic [TCOUNT_W-1:0] popcount(input logic [MAX_NT-1:0] v);
        logic [TCOUNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_NT; i++) begin
            c = c + {1'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/sbqm_debounce.sv
// Entry photocell conditioner: two-flop synchronizer, DEB-sample stability filter,
// and a one-cycle pulse on each debounced rising edge.
module sbqm_debounce #(
    parameter int DEB = 4
) (
    input  logic clk,
    input  logic Reset,
    input  logic sensor_in,
    output logic rise
);
    localparam int CNT_W = $clog2(DEB + 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive synced samples that disagree with the filtered level
    always_comb begin
        stable_d = stable_q;
        rise_d   = 1'b0;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEB - 1)) begin
                stable_d = sync2_q;
                rise_d   = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sensor_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/sbqm_teller_scheduler.sv
// Front-end controller: entry pulses, round-robin teller calls, open-teller count.
// Optional grant timeout enabled by defining SBQM_GRANT_TIMEOUT_EN.
module sbqm_teller_scheduler
    import sbqm_pkg::*;
#(
    parameter int N       = 3,
    parameter int NT      = 3,
    parameter int DEB     = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                sensor_in,
    input  logic [NT-1:0]       teller_open,
    input  logic [NT-1:0]       teller_req,
    input  logic [N-1:0]        pcount,
    input  logic                empty_flag,
    input  logic                full_flag,
    output logic                up_count,
    output logic                down_count,
    output logic [NT-1:0]       grant,
    output logic [TCOUNT_W-1:0] tcount,
    output logic                reject,
    output logic                timeout_err
);
    localparam int PTR_W = 2;

    logic                rise;
    logic [NT-1:0]       eligible;
    logic                pick_found;
    logic [PTR_W-1:0]    pick_idx;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    gidx_q, gidx_d;
    logic [NT-1:0]       grant_q, grant_d;
    logic                down_q, down_d;
    logic                up_q, up_d;
    logic                reject_q, reject_d;
    logic [TCOUNT_W-1:0] tcount_q, tcount_d;
`ifdef SBQM_GRANT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                terr_q, terr_d;
`else
    logic                unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    sbqm_debounce #(.DEB(DEB)) u_debounce (
        .clk       (clk),
        .Reset     (Reset),
        .sensor_in (sensor_in),
        .rise      (rise)
    );

    assign eligible = teller_open & teller_req;

    // First eligible teller at or after the round-robin pointer, wrapping
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        for (int j = 0; j < NT; j++) begin
            int cand;
            cand = int'(ptr_q) + j;
            if (cand >= NT) cand = cand - NT;
            if (!pick_found && eligible[cand[PTR_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        down_d   = 1'b0;
        up_d     = rise & ~full_flag;
        reject_d = rise & full_flag;
        tcount_d = popcount(MAX_NT'(teller_open));
`ifdef SBQM_GRANT_TIMEOUT_EN
        tmo_d    = tmo_q;
        terr_d   = terr_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found && !empty_flag && pcount != '0) begin
                    state_d           = GRANT;
                    gidx_d            = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    down_d            = 1'b1;
                    ptr_d             = (pick_idx == PTR_W'(NT - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            GRANT: begin
                state_d = HOLD;
`ifdef SBQM_GRANT_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            HOLD: begin
                if (!teller_req[gidx_q] || !teller_open[gidx_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
`ifdef SBQM_GRANT_TIMEOUT_EN
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    terr_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            down_q   <= 1'b0;
            up_q     <= 1'b0;
            reject_q <= 1'b0;
            tcount_q <= '0;
`ifdef SBQM_GRANT_TIMEOUT_EN
            tmo_q    <= '0;
            terr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            down_q   <= down_d;
            up_q     <= up_d;
            reject_q <= reject_d;
            tcount_q <= tcount_d;
`ifdef SBQM_GRANT_TIMEOUT_EN
            tmo_q    <= tmo_d;
            terr_q   <= terr_d;
`endif
        end
    end

    assign up_count   = up_q;
    assign down_count = down_q;
    assign grant      = grant_q;
    assign tcount     = tcount_q;
    assign reject     = reject_q;
`ifdef SBQM_GRANT_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sbqm_teller_scheduler.sv
// Bench for sbqm_teller_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_sbqm_teller_scheduler;
    localparam int N       = 3;
    localparam int NT      = 3;
    localparam int DEB     = 4;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          Reset;
    logic          sensor_in;
    logic [NT-1:0] teller_open;
    logic [NT-1:0] teller_req;
    logic [N-1:0]  pcount;
    logic          empty_flag;
    logic          full_flag;
    logic          up_count;
    logic          down_count;
    logic [NT-1:0] grant;
    logic [1:0]    tcount;
    logic          reject;
    logic          timeout_err;

    always #5 clk = ~clk;

    sbqm_teller_scheduler #(.N(N), .NT(NT), .DEB(DEB), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .sensor_in   (sensor_in),
        .teller_open (teller_open),
        .teller_req  (teller_req),
        .pcount      (pcount),
        .empty_flag  (empty_flag),
        .full_flag   (full_flag),
        .up_count    (up_count),
        .down_count  (down_count),
        .grant       (grant),
        .tcount      (tcount),
        .reject      (reject),
        .timeout_err (timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: sensor history queue, sliding stability window, teller owner
    int            m_hist[$];
    int            m_win[$];
    int            m_db, m_rise;
    int            m_ptr, m_owner, m_phase, m_hold;
    logic          e_up, e_rej, e_down, e_terr;
    logic [1:0]    e_tc;
    logic [NT-1:0] e_grant;

    function automatic void model_reset();
        m_hist = {0, 0};
        m_win.delete();
        for (int i = 0; i < DEB; i++) m_win.push_back(0);
        m_db = 0; m_rise = 0;
        m_ptr = 0; m_owner = -1; m_phase = 0; m_hold = 0;
        e_up = 0; e_rej = 0; e_down = 0; e_terr = 0; e_tc = 0; e_grant = '0;
    endfunction

    function automatic void model_step();
        int s;
        int all_diff;
        if (Reset) begin
            model_reset();
            return;
        end
        e_up  = (m_rise != 0) && !full_flag;
        e_rej = (m_rise != 0) && full_flag;
        s = m_hist.pop_front();
        m_hist.push_back(int'(sensor_in));
        void'(m_win.pop_front());
        m_win.push_back(s);
        all_diff = 1;
        foreach (m_win[i]) if (m_win[i] == m_db) all_diff = 0;
        m_rise = 0;
        if (all_diff != 0) begin
            m_db   = 1 - m_db;
            m_rise = m_db;
        end
        e_tc   = 2'($countones(teller_open));
        e_down = 0;
        if (m_phase == 0) begin
            for (int j = 0; j < NT; j++) begin
                int c;
                c = (m_ptr + j) % NT;
                if (m_phase == 0 && teller_open[c] && teller_req[c] && !empty_flag && pcount != 0) begin
                    m_owner = c;
                    m_phase = 1;
                    e_down  = 1;
                    m_ptr   = (c + 1) % NT;
                end
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_hold  = 0;
        end else begin
            if (!teller_req[m_owner] || !teller_open[m_owner]) begin
                m_owner = -1;
                m_phase = 0;
            end else begin
`ifdef SBQM_GRANT_TIMEOUT_EN
                m_hold++;
                if (m_hold == TIMEOUT) begin
                    m_owner = -1;
                    m_phase = 0;
                    e_terr  = 1;
                end
`endif
            end
        end
        e_grant = '0;
        if (m_owner >= 0) e_grant[m_owner] = 1'b1;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("up_count", up_count, e_up);
        chk("reject", reject, e_rej);
        chk("down_count", down_count, e_down);
        chk("grant", grant, e_grant);
        chk("tcount", tcount, e_tc);
        chk("timeout_err", timeout_err, e_terr);
    endtask

    logic [NT-1:0] seq [4];
    logic [NT-1:0] exp_seq [4];
    int ups, rejs, downs, lat, gcount;

    initial begin
        model_reset();
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
        seq     = '{default: '0};
        Reset = 1'b1; sensor_in = 1'b0; teller_open = '0; teller_req = '0;
        pcount = '0; empty_flag = 1'b1; full_flag = 1'b0;

        // Reset held with inputs toggling: everything stays quiet
        for (int i = 0; i < 4; i++) begin
            sensor_in   = 1'($urandom);
            teller_open = NT'($urandom);
            teller_req  = NT'($urandom);
            pcount      = N'($urandom);
            empty_flag  = 1'($urandom);
            full_flag   = 1'($urandom);
            cycle();
            chk("rst_grant", grant, 0);
            chk("rst_tcount", tcount, 0);
        end
        Reset = 1'b0; sensor_in = 1'b0; teller_open = '0; teller_req = '0;
        pcount = '0; empty_flag = 1'b1; full_flag = 1'b0;
        repeat (8) cycle();

        // Clean entry: one up_count after sync + DEB + 1 cycles
        sensor_in = 1'b1; ups = 0; lat = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (up_count) begin ups++; lat = i; end
        end
        chk("entry_count", ups, 1);
        chk("entry_latency", lat, 2 + DEB + 1);
        sensor_in = 1'b0;
        repeat (10) cycle();

        // Two-cycle glitch is filtered
        ups = 0;
        sensor_in = 1'b1; cycle(); cycle(); sensor_in = 1'b0;
        for (int i = 0; i < 12; i++) begin cycle(); if (up_count) ups++; end
        chk("glitch_count", ups, 0);

        // Entry while full: reject instead of up_count
        full_flag = 1'b1; sensor_in = 1'b1; ups = 0; rejs = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (up_count) ups++;
            if (reject) rejs++;
        end
        chk("full_reject", rejs, 1);
        chk("full_up", ups, 0);
        sensor_in = 1'b0; full_flag = 1'b0;
        repeat (10) cycle();

        // Round-robin with a 4-phase teller handshake
        teller_open = 3'b111; teller_req = 3'b111; pcount = 3'd5; empty_flag = 1'b0;
        gcount = 0;
        for (int i = 0; i < 60 && gcount < 4; i++) begin
            cycle();
            if (down_count) begin seq[gcount] = grant; gcount++; end
            teller_req = ~grant;
        end
        chk("rr_grants", gcount, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), seq[i], exp_seq[i]);
        teller_req = '0;
        repeat (4) cycle();

        // Empty queue blocks the call until it clears
        teller_req = 3'b010; empty_flag = 1'b1; downs = 0;
        for (int i = 0; i < 5; i++) begin cycle(); if (down_count) downs++; end
        chk("empty_block", downs, 0);
        empty_flag = 1'b0;
        cycle();
        chk("empty_release_grant", grant, 3'b010);
        chk("empty_release_down", down_count, 1);
        teller_req = '0;
        repeat (4) cycle();

`ifdef SBQM_GRANT_TIMEOUT_EN
        // Grant held past TIMEOUT hold cycles drops and sets the sticky flag
        teller_req = 3'b001; lat = 0;
        for (int i = 0; i < 4; i++) begin cycle(); if (down_count) break; end
        lat = 1;
        for (int i = 0; i < 40 && grant[0]; i++) begin cycle(); if (grant[0]) lat++; end
        chk("timeout_hold", lat, TIMEOUT + 1);
        chk("timeout_flag", timeout_err, 1);
        teller_req = '0;
        repeat (3) cycle();
        chk("timeout_sticky", timeout_err, 1);
        Reset = 1'b1; cycle(); Reset = 1'b0;
        chk("timeout_cleared", timeout_err, 0);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            Reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 5) == 0) sensor_in = ~sensor_in;
            if ($urandom_range(0, 9) == 0) full_flag = ~full_flag;
            pcount     = N'($urandom_range(0, 7));
            empty_flag = (pcount == 0) ^ ($urandom_range(0, 9) == 0);
            for (int i = 0; i < NT; i++) begin
                if (grant[i]) begin
                    if ($urandom_range(0, 2) == 0) teller_req[i] = 1'b0;
                end else if (!teller_req[i]) begin
                    if ($urandom_range(0, 3) == 0) teller_req[i] = 1'b1;
                end else if ($urandom_range(0, 29) == 0) begin
                    teller_req[i] = 1'b0;
                end
                if ($urandom_range(0, 19) == 0) teller_open[i] = ~teller_open[i];
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
